// File: rtl/bcd_seq_ctrl_if.sv
// Request/grant/result bundle between two conversion requesters and the
// shared binary-to-BCD sequencer.
interface bcd_seq_ctrl_if;
   logic       REQ_A;
   logic [7:0] BIN_A;
   logic       REQ_B;
   logic [7:0] BIN_B;
   logic       GNT_A;
   logic       GNT_B;
   logic       BUSY;
   logic       DONE;
   logic       SRC;
   logic [3:0] H;
   logic [3:0] T;
   logic [3:0] O;

   modport master (
      output REQ_A, BIN_A, REQ_B, BIN_B,
      input  GNT_A, GNT_B, BUSY, DONE, SRC, H, T, O
   );

   modport slave (
      input  REQ_A, BIN_A, REQ_B, BIN_B,
      output GNT_A, GNT_B, BUSY, DONE, SRC, H, T, O
   );
endinterface

// File: rtl/bcd_seq_ctrl.sv
// Two-requester round-robin front end around a serial double-dabble
// converter: 8-bit binary in, three registered BCD digits out.
module bcd_seq_ctrl (
   input  logic         CLK,
   input  logic         RST,
   bcd_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        prefer_b_q, prefer_b_d;
   logic        gnt_a_q, gnt_a_d;
   logic        gnt_b_q, gnt_b_d;
   logic        src_q, src_d;
   logic [3:0]  h_q, h_d;
   logic [3:0]  t_q, t_d;
   logic [3:0]  o_q, o_d;

   logic [7:0]  sr_q, sr_d;
   logic [11:0] bcd_q, bcd_d;
   logic        owner_q, owner_d;

   logic        pick_b;
   logic [11:0] bcd_adj;
   logic [19:0] shifted;

   function automatic logic [3:0] adj_digit(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prefer_b_d = prefer_b_q;
      gnt_a_d    = 1'b0;
      gnt_b_d    = 1'b0;
      src_d      = src_q;
      h_d        = h_q;
      t_d        = t_q;
      o_d        = o_q;
      sr_d       = sr_q;
      bcd_d      = bcd_q;
      owner_d    = owner_q;
      pick_b     = 1'b0;

      bcd_adj = {adj_digit(bcd_q[11:8]), adj_digit(bcd_q[7:4]), adj_digit(bcd_q[3:0])};
      shifted = {bcd_adj, sr_q} << 1;

      case (state_q)
         IDLE: begin
            if (bus.REQ_A || bus.REQ_B) begin
               // B wins when alone, or when both ask and A was served last.
               pick_b     = bus.REQ_B && (!bus.REQ_A || prefer_b_q);
               owner_d    = pick_b;
               sr_d       = pick_b ? bus.BIN_B : bus.BIN_A;
               bcd_d      = 12'd0;
               cnt_d      = 3'd0;
               gnt_a_d    = !pick_b;
               gnt_b_d    = pick_b;
               prefer_b_d = !pick_b;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = shifted[19:8];
            sr_d  = shifted[7:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               h_d     = shifted[19:16];
               t_d     = shifted[15:12];
               o_d     = shifted[11:8];
               src_d   = owner_q;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         prefer_b_q <= 1'b0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         src_q      <= 1'b0;
         h_q        <= 4'd0;
         t_q        <= 4'd0;
         o_q        <= 4'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prefer_b_q <= prefer_b_d;
         gnt_a_q    <= gnt_a_d;
         gnt_b_q    <= gnt_b_d;
         src_q      <= src_d;
         h_q        <= h_d;
         t_q        <= t_d;
         o_q        <= o_d;
      end
   end

   // Working registers are always reloaded on acceptance, so they need no reset.
   always_ff @(posedge CLK) begin
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      owner_q <= owner_d;
   end

   assign bus.GNT_A = gnt_a_q;
   assign bus.GNT_B = gnt_b_q;
   assign bus.BUSY  = (state_q != IDLE);
   assign bus.DONE  = (state_q == FIN);
   assign bus.SRC   = src_q;
   assign bus.H     = h_q;
   assign bus.T     = t_q;
   assign bus.O     = o_q;

endmodule
